// File: rtl/clk_switch_ctrl.sv
// Sequencing controller for the glitch-free clock mux: handshake, settle window, dwell window.
// Optional switch counter (sw_count) enabled by defining CLK_SW_CNT_EN.
//
// state  | meaning
// IDLE   | waiting for a request; req_ready may be high
// SETTLE | sel changed, waiting for the mux handover to finish
// DWELL  | minimum residency on the new clock before another switch
module clk_switch_ctrl #(
  parameter int SETTLE_CYCLES = 8,
  parameter int DWELL_CYCLES  = 16,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic             req_sel,
  output logic             req_ready,
  input  logic             lock,
  output logic             sel,
  output logic             cur_sel,
  output logic             busy,
  output logic             switch_done
`ifdef CLK_SW_CNT_EN
  ,
  output logic [CNT_W-1:0] sw_count
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DWELL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LOAD  = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t           state_q, state_d;
  logic             sel_q, sel_d;
  logic             cur_sel_q, cur_sel_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
`ifdef CLK_SW_CNT_EN
  logic [CNT_W-1:0] sw_count_q, sw_count_d;
`endif

  // rst_n term keeps ready low for the whole reset window, not just after the first edge
  assign req_ready = (state_q == IDLE) && !lock && rst_n;
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cur_sel_d = cur_sel_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
`ifdef CLK_SW_CNT_EN
    sw_count_d = sw_count_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_sel != sel_q) begin
            sel_d   = req_sel;
            cnt_d   = SETTLE_LOAD;
            state_d = SETTLE;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          cur_sel_d = sel_q;
          done_d    = 1'b1;
          cnt_d     = DWELL_LOAD;
          state_d   = DWELL;
`ifdef CLK_SW_CNT_EN
          sw_count_d = sw_count_q + CNT_ONE;
`endif
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      DWELL: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sel_q     <= 1'b0;
      cur_sel_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
`ifdef CLK_SW_CNT_EN
      sw_count_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      cur_sel_q <= cur_sel_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
`ifdef CLK_SW_CNT_EN
      sw_count_q <= sw_count_d;
`endif
    end
  end

  assign sel         = sel_q;
  assign cur_sel     = cur_sel_q;
  assign busy        = busy_q;
  assign switch_done = done_q;
`ifdef CLK_SW_CNT_EN
  assign sw_count    = sw_count_q;
`endif

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Bench for clk_switch_ctrl: directed scenarios then random traffic against a timeline model
// that tracks when the current switch completes and when the controller is free again.
module tb_clk_switch_ctrl;
  localparam int S = 8;
  localparam int D = 16;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0;
  logic req_sel = 1'b0;
  logic lock = 1'b0;
  logic req_ready, sel, cur_sel, busy, switch_done;
`ifdef CLK_SW_CNT_EN
  logic [W-1:0] sw_count;
`endif

  clk_switch_ctrl #(.SETTLE_CYCLES(S), .DWELL_CYCLES(D), .CNT_W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_sel    (req_sel),
    .req_ready  (req_ready),
    .lock       (lock),
    .sel        (sel),
    .cur_sel    (cur_sel),
    .busy       (busy),
    .switch_done(switch_done)
`ifdef CLK_SW_CNT_EN
    ,
    .sw_count   (sw_count)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // timeline model: k counts edges; t_done is the edge that completes a switch,
  // t_idle the edge after which the controller is free again
  int k = 0;
  int t_done = -1;
  int t_idle = 0;
  bit m_sel = 1'b0;
  bit m_cur = 1'b0;
  bit m_same = 1'b0;
  int m_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sel  = 1'b0;
    m_cur  = 1'b0;
    m_same = 1'b0;
    m_cnt  = 0;
    t_done = -1;
    t_idle = k;
  endtask

  task automatic check_all();
    bit m_busy;
    m_busy = rst_n && (k < t_idle);
    chk("sel", 32'(sel), 32'(m_sel));
    chk("cur_sel", 32'(cur_sel), 32'(m_cur));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("switch_done", 32'(switch_done), 32'(rst_n && ((k == t_done) || m_same)));
    chk("req_ready", 32'(req_ready), 32'(rst_n && !m_busy && !lock));
`ifdef CLK_SW_CNT_EN
    chk("sw_count", 32'(sw_count), 32'(m_cnt));
`endif
  endtask

  // one clock edge with the inputs already applied, then model update and check
  task automatic cycle();
    @(posedge clk);
    k++;
    m_same = 1'b0;
    if (rst_n) begin
      if (k == t_done) begin
        m_cur = m_sel;
        m_cnt = (m_cnt + 1) % (1 << W);
      end
      if (req_valid && !lock && (k - 1 >= t_idle)) begin
        if (req_sel != m_sel) begin
          m_sel  = req_sel;
          t_done = k + S;
          t_idle = k + S + D;
        end else begin
          m_same = 1'b1;
        end
      end
    end
    #1;
    check_all();
  endtask

  task automatic drive(input bit v, input bit s, input bit l, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (!rst_n) rst_n = 1'b1;
      req_valid = v;
      req_sel   = s;
      lock      = l;
      cycle();
    end
  endtask

  // asynchronous reset between edges; outputs must clear without a clock
  task automatic async_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    cycle();
  endtask

  initial begin
    // reset state with lock low
    #2;
    model_reset();
    check_all();
    drive(0, 0, 0, 2);
    drive(0, 0, 0, 3);
    // 0->1 switch, then a held 1->0 request that must wait out settle+dwell
    drive(1, 1, 0, 1);
    drive(1, 0, 0, S + D + S + 4);
    drive(0, 0, 0, D + 2);
    // same-sel request: pulse only, never busy
    drive(1, 0, 0, 1);
    drive(0, 0, 0, 3);
    // lock in IDLE blocks, lock during SETTLE does not abort
    drive(1, 1, 1, 5);
    drive(1, 1, 0, 1);
    drive(0, 0, 1, S + D + 2);
    drive(1, 0, 1, 4);
    drive(1, 0, 0, 1);
    drive(0, 0, 0, S + D + 2);
    // reset four cycles into SETTLE
    drive(1, 1, 0, 1);
    drive(0, 0, 0, 3);
    async_reset();
    drive(0, 0, 0, 2);
    // four real switches
    for (int j = 0; j < 4; j++) begin
      drive(1, (j % 2 == 0), 0, 1);
      drive(0, 0, 0, S + D + 1);
    end
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        async_reset();
      end else begin
        drive(($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 7) == 0), 1);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
